// File: rtl/sal_bank_timer_if.sv
// sal_bank_timer_if: command, timing-parameter and legality-flag bundle between controller and bank timer
interface sal_bank_timer_if #(parameter int CNT_W = 8, parameter int ROW_W = 14);
  logic             cmd_valid;
  logic [2:0]       cmd_type;
  logic [ROW_W-1:0] cmd_row;
  logic [CNT_W-1:0] t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1;
  logic             act_ok, rdwr_ok, pre_ok, ref_ok, row_open, err;
  logic [ROW_W-1:0] open_row;
  modport master (
    output cmd_valid, cmd_type, cmd_row,
    output t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1,
    input  act_ok, rdwr_ok, pre_ok, ref_ok, row_open, open_row, err
  );
  modport slave (
    input  cmd_valid, cmd_type, cmd_row,
    input  t_rcd_m1, t_ras_m1, t_rc_m1, t_rp_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1,
    output act_ok, rdwr_ok, pre_ok, ref_ok, row_open, open_row, err
  );
endinterface

// File: rtl/sal_bank_timer.sv
// sal_bank_timer: per-bank DDR2 row state and ACT/RD/WR/PRE/REF spacing guard with sticky error flag
module sal_bank_timer #(parameter int CNT_W = 8, parameter int ROW_W = 14) (
  input logic clk,
  input logic rst,
  sal_bank_timer_if.slave bus
);
  typedef enum logic {CLOSED, OPEN} state_t;
  localparam logic [2:0] C_ACT = 3'd0, C_RD = 3'd1, C_WR = 3'd2, C_PRE = 3'd3, C_REF = 3'd4;
  state_t state, state_nxt;
  logic [CNT_W-1:0] rcd, ras, rc, rp, rtp, wtp, rfc;
  logic [ROW_W-1:0] open_row_q;
  logic err_q, legal, acc;
  logic ld_act, ld_rd, ld_wr, ld_pre, ld_ref;
  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return v - CNT_W'(v != '0);
  endfunction
  assign bus.act_ok   = (state == CLOSED) && rc == '0 && rp == '0 && rfc == '0;
  assign bus.ref_ok   = bus.act_ok;
  assign bus.rdwr_ok  = (state == OPEN) && rcd == '0;
  assign bus.pre_ok   = (state == OPEN) && ras == '0 && rtp == '0 && wtp == '0;
  assign bus.row_open = (state == OPEN);
  assign bus.open_row = open_row_q;
  assign bus.err      = err_q;
  always_comb begin
    legal = bus.cmd_type == C_ACT ? bus.act_ok :
            bus.cmd_type == C_RD  ? bus.rdwr_ok :
            bus.cmd_type == C_WR  ? bus.rdwr_ok :
            bus.cmd_type == C_PRE ? bus.pre_ok :
            bus.cmd_type == C_REF ? bus.ref_ok : 1'b0;
    acc = bus.cmd_valid && legal;
    ld_act = acc && bus.cmd_type == C_ACT;
    ld_rd  = acc && bus.cmd_type == C_RD;
    ld_wr  = acc && bus.cmd_type == C_WR;
    ld_pre = acc && bus.cmd_type == C_PRE;
    ld_ref = acc && bus.cmd_type == C_REF;
    state_nxt = ld_act ? OPEN : ld_pre ? CLOSED : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLOSED;
    else state <= state_nxt;
  end
  // a load always replaces the running count, even a larger one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rcd, ras, rc, rp, rtp, wtp, rfc} <= '0;
      open_row_q <= '0;
      err_q <= 1'b0;
    end else begin
      rcd <= ld_act ? bus.t_rcd_m1 : dec(rcd);
      ras <= ld_act ? bus.t_ras_m1 : dec(ras);
      rc  <= ld_act ? bus.t_rc_m1  : dec(rc);
      rtp <= ld_rd  ? bus.t_rtp_m1 : dec(rtp);
      wtp <= ld_wr  ? bus.t_wtp_m1 : dec(wtp);
      rp  <= ld_pre ? bus.t_rp_m1  : dec(rp);
      rfc <= ld_ref ? bus.t_rfc_m1 : dec(rfc);
      open_row_q <= ld_act ? bus.cmd_row : open_row_q;
      err_q <= err_q | (bus.cmd_valid & ~legal);
    end
  end
endmodule

// File: tb/tb_sal_bank_timer.sv
// tb_sal_bank_timer: directed checks of spacing, row state, error flag and async reset
module tb_sal_bank_timer;
  logic clk = 1'b0, rst = 1'b1;
  int nc = 0, nf = 0;
  sal_bank_timer_if #(.CNT_W(8), .ROW_W(14)) bus ();
  sal_bank_timer #(.CNT_W(8), .ROW_W(14)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 3'd0; bus.cmd_row = '0;
    bus.t_rcd_m1 = 0; bus.t_ras_m1 = 0; bus.t_rc_m1 = 0; bus.t_rp_m1 = 0;
    bus.t_rtp_m1 = 0; bus.t_wtp_m1 = 0; bus.t_rfc_m1 = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask
  task automatic issue(input logic [2:0] t, input logic [13:0] row);
    bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_row = row;
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL reset_act_ok got %b exp 1", bus.act_ok); end
    nc++; if (bus.ref_ok !== 1'b1) begin nf++; $display("FAIL reset_ref_ok got %b exp 1", bus.ref_ok); end
    nc++; if (bus.rdwr_ok !== 1'b0) begin nf++; $display("FAIL reset_rdwr_ok got %b exp 0", bus.rdwr_ok); end
    nc++; if (bus.pre_ok !== 1'b0) begin nf++; $display("FAIL reset_pre_ok got %b exp 0", bus.pre_ok); end
    nc++; if (bus.err !== 1'b0) begin nf++; $display("FAIL reset_err got %b exp 0", bus.err); end
    nc++; if (bus.row_open !== 1'b0) begin nf++; $display("FAIL reset_row_open got %b exp 0", bus.row_open); end
    nc++; if (bus.open_row !== 14'h0) begin nf++; $display("FAIL reset_open_row got %h exp 0", bus.open_row); end
  endtask
  task automatic test_act_rcd();
    do_reset();
    bus.t_rcd_m1 = 3;
    issue(3'd0, 14'h1A5);
    bus.t_rcd_m1 = 9;
    for (int c = 1; c <= 4; c++) begin
      nc++; if (bus.rdwr_ok !== (c >= 4)) begin nf++; $display("FAIL rcd_rdwr_ok T+%0d got %b exp %b", c, bus.rdwr_ok, c >= 4); end
      cyc(1);
    end
    nc++; if (bus.row_open !== 1'b1) begin nf++; $display("FAIL act_row_open got %b exp 1", bus.row_open); end
    nc++; if (bus.open_row !== 14'h1A5) begin nf++; $display("FAIL act_open_row got %h exp 1a5", bus.open_row); end
    nc++; if (bus.act_ok !== 1'b0) begin nf++; $display("FAIL act_open_act_ok got %b exp 0", bus.act_ok); end
  endtask
  task automatic test_pre_rtp();
    do_reset();
    bus.t_ras_m1 = 7; bus.t_rtp_m1 = 2; bus.t_rcd_m1 = 2;
    issue(3'd0, 14'h10);
    cyc(5);
    issue(3'd1, 14'h0);
    for (int c = 7; c <= 9; c++) begin
      nc++; if (bus.pre_ok !== (c >= 9)) begin nf++; $display("FAIL rtp_pre_ok cycle %0d got %b exp %b", c, bus.pre_ok, c >= 9); end
      if (c < 9) cyc(1);
    end
    issue(3'd1, 14'h0);
    for (int c = 10; c <= 12; c++) begin
      nc++; if (bus.pre_ok !== (c >= 12)) begin nf++; $display("FAIL rd_repeat_pre_ok cycle %0d got %b exp %b", c, bus.pre_ok, c >= 12); end
      if (c < 12) cyc(1);
    end
    bus.t_wtp_m1 = 5;
    issue(3'd2, 14'h0);
    bus.t_wtp_m1 = 0;
    cyc(1);
    issue(3'd2, 14'h0);
    nc++; if (bus.pre_ok !== 1'b1) begin nf++; $display("FAIL wtp_reload_shorter got %b exp 1", bus.pre_ok); end
    nc++; if (bus.err !== 1'b0) begin nf++; $display("FAIL rtp_err got %b exp 0", bus.err); end
  endtask
  task automatic test_act_rc();
    do_reset();
    bus.t_rp_m1 = 4; bus.t_rc_m1 = 20; bus.t_ras_m1 = 7;
    issue(3'd0, 14'h2B);
    cyc(7);
    issue(3'd3, 14'h0);
    nc++; if (bus.row_open !== 1'b0) begin nf++; $display("FAIL pre_row_open got %b exp 0", bus.row_open); end
    nc++; if (bus.open_row !== 14'h2B) begin nf++; $display("FAIL pre_open_row_hold got %h exp 2b", bus.open_row); end
    for (int c = 9; c <= 21; c++) begin
      nc++; if (bus.act_ok !== (c >= 21)) begin nf++; $display("FAIL rc_act_ok cycle %0d got %b exp %b", c, bus.act_ok, c >= 21); end
      nc++; if (bus.ref_ok !== (c >= 21)) begin nf++; $display("FAIL rc_ref_ok cycle %0d got %b exp %b", c, bus.ref_ok, c >= 21); end
      if (c < 21) cyc(1);
    end
    nc++; if (bus.err !== 1'b0) begin nf++; $display("FAIL rc_err got %b exp 0", bus.err); end
  endtask
  task automatic test_illegal();
    do_reset();
    issue(3'd1, 14'h0);
    nc++; if (bus.err !== 1'b1) begin nf++; $display("FAIL rd_closed_err got %b exp 1", bus.err); end
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL rd_closed_act_ok got %b exp 1", bus.act_ok); end
    nc++; if (bus.row_open !== 1'b0) begin nf++; $display("FAIL rd_closed_row_open got %b exp 0", bus.row_open); end
    cyc(3);
    nc++; if (bus.err !== 1'b1) begin nf++; $display("FAIL err_sticky got %b exp 1", bus.err); end
    do_reset();
    bus.t_rc_m1 = 9;
    issue(3'd6, 14'h3);
    nc++; if (bus.err !== 1'b1) begin nf++; $display("FAIL reserved_err got %b exp 1", bus.err); end
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL reserved_act_ok got %b exp 1", bus.act_ok); end
    do_reset();
    issue(3'd0, 14'h55);
    issue(3'd0, 14'h77);
    nc++; if (bus.err !== 1'b1) begin nf++; $display("FAIL act_open_err got %b exp 1", bus.err); end
    nc++; if (bus.open_row !== 14'h55) begin nf++; $display("FAIL act_open_row_kept got %h exp 55", bus.open_row); end
    do_reset();
    issue(3'd0, 14'h12);
    bus.t_rfc_m1 = 9;
    issue(3'd4, 14'h0);
    nc++; if (bus.err !== 1'b1) begin nf++; $display("FAIL ref_open_err got %b exp 1", bus.err); end
    nc++; if (bus.row_open !== 1'b1) begin nf++; $display("FAIL ref_open_row_open got %b exp 1", bus.row_open); end
    issue(3'd3, 14'h0);
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL ref_open_no_rfc got %b exp 1", bus.act_ok); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.t_rfc_m1 = 50;
    issue(3'd4, 14'h0);
    nc++; if (bus.act_ok !== 1'b0) begin nf++; $display("FAIL rfc_act_ok got %b exp 0", bus.act_ok); end
    nc++; if (bus.row_open !== 1'b0) begin nf++; $display("FAIL ref_row_open got %b exp 0", bus.row_open); end
    cyc(19);
    nc++; if (bus.ref_ok !== 1'b0) begin nf++; $display("FAIL rfc_ref_ok_c20 got %b exp 0", bus.ref_ok); end
    #2 rst = 1'b1;
    #1;
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL async_rst_act_ok got %b exp 1", bus.act_ok); end
    nc++; if (bus.ref_ok !== 1'b1) begin nf++; $display("FAIL async_rst_ref_ok got %b exp 1", bus.ref_ok); end
    cyc(1);
    rst = 1'b0;
    cyc(1);
    nc++; if (bus.act_ok !== 1'b1) begin nf++; $display("FAIL post_rst_act_ok got %b exp 1", bus.act_ok); end
  endtask
  initial begin
    test_reset();
    test_act_rcd();
    test_pre_rtp();
    test_act_rc();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
